// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg : shared types and constants for the FPU result write-back path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  typedef struct packed {
    logic [31:0] result;
    fpu_flags_t  flags;
    logic [4:0]  rd;
  } wb_entry_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] value);
    return (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
// ----------------------------------------------------------------------------
// fpu_wb_fifo : 2-entry in-order buffer of pending FP register-file writes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_wb_fifo
  import fpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      not_full,
  output logic      not_empty,
  output wb_entry_t head
);

  wb_entry_t  mem [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       not_full_q;
  logic       do_push;
  logic       do_pop;

  assign not_empty = (count != 2'd0);
  assign not_full  = not_full_q;
  assign do_push   = push & not_full_q;
  assign do_pop    = pop & not_empty;
  assign head      = mem[rptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Space flag is registered from the next count, so a pop while full only
  // reopens the input on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      count      <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_entry;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      count      <= count_next;
      not_full_q <= (count_next != 2'd2);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_result_wb.sv
// ----------------------------------------------------------------------------
// fpu_result_wb : buffers FPU results, retires them to the FP register file
//                 and accrues exception flags. Option: FPU_NAN_CANON_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_result_wb
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_flags,
  input  logic [4:0]  in_rd,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        csr_we,
  input  logic [4:0]  csr_wdata,
  output logic [4:0]  fflags,
  output logic        busy
);

  wb_entry_t   push_entry;
  wb_entry_t   head;
  logic [31:0] push_result;
  logic        push;
  logic        pop;
  logic        not_full;
  logic        not_empty;
  logic [4:0]  fflags_q;
  logic [4:0]  fflags_next;

`ifdef FPU_NAN_CANON_EN
  assign push_result = is_nan(in_result) ? CANON_NAN : in_result;
`else
  assign push_result = in_result;
`endif

  assign push_entry = '{result: push_result, flags: fpu_flags_t'(in_flags), rd: in_rd};
  assign push       = in_valid & not_full;
  assign pop        = not_empty & wb_ready;

  fpu_wb_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .not_full   (not_full),
    .not_empty  (not_empty),
    .head       (head)
  );

  assign in_ready = not_full;
  assign wb_valid = not_empty;
  assign busy     = not_empty;
  assign wb_rd    = head.rd;
  assign wb_data  = head.result;
  assign fflags   = fflags_q;

  // The retiring entry's flags are OR-ed on top of any CSR write so they survive it.
  always_comb begin
    fflags_next = csr_we ? csr_wdata : fflags_q;
    if (pop) begin
      fflags_next = fflags_next | 5'(head.flags);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fflags_q <= 5'd0;
    end else begin
      fflags_q <= fflags_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_wb.sv
// ----------------------------------------------------------------------------
// tb_fpu_result_wb : scoreboard bench for fpu_result_wb (honours FPU_NAN_CANON_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fpu_result_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_flags;
  logic [4:0]  in_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        csr_we;
  logic [4:0]  csr_wdata;
  logic [4:0]  fflags;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [4:0] acc_flags;

  fpu_result_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_flags  (in_flags),
    .in_rd     (in_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .fflags    (fflags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Every write the register file will take at the next edge is checked here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        if ({wb_data, wb_rd} !== {mon_e.data, mon_e.rd}) begin
          n_fail++;
          $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd, wb_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(input logic [31:0] r);
`ifdef FPU_NAN_CANON_EN
    if (r[30:23] == 8'hFF && r[22:0] != 23'd0) return 32'h7FC00000;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one offer for one edge; scoreboard it only if it will be accepted.
  task automatic offer(input logic [31:0] r, input logic [4:0] f, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    in_rd     = rd;
    if (in_ready) sb.push_back('{data: exp_data(r), flags: f, rd: rd});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, wb_valid, busy, fflags, wb_rd, wb_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b busy=%b ff=%b rd=%0d data=%h, required 1 0 0 00000 0 0",
               in_ready, wb_valid, busy, fflags, wb_rd, wb_data);
    end
  endtask

  task automatic test_single();
    wb_ready = 1'b1;
    offer(32'h3F800000, 5'b00001, 5'd3);
    n_checks++;
    if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h3F800000, 5'd3}) begin
      n_fail++;
      $display("FAIL single_latency: got v=%b data=%h rd=%0d, required 1 3f800000 3", wb_valid, wb_data, wb_rd);
    end
    n_checks++;
    if (fflags !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_no_accrue_at_push: got %b, required 00000", fflags);
    end
    tick();
    n_checks++;
    if ({fflags, wb_valid, busy} !== {5'b00001, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_flags: got ff=%b v=%b busy=%b, required 00001 0 0", fflags, wb_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b, required 1", in_ready); end
    offer(32'h40000000, 5'b00010, 5'd4);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %b, required 1", in_ready); end
    offer(32'h40400000, 5'b00100, 5'd5);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b, required 0", in_ready); end
    offer(32'h40800000, 5'b01000, 5'd6);
    tick();
    n_checks++;
    if ({wb_valid, busy, in_ready, wb_data, wb_rd} !== {1'b1, 1'b1, 1'b0, 32'h40000000, 5'd4}) begin
      n_fail++;
      $display("FAIL b2b_hold: got v=%b busy=%b rdy=%b data=%h rd=%0d, required 1 1 0 40000000 4",
               wb_valid, busy, in_ready, wb_data, wb_rd);
    end
    wb_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, wb_valid, wb_data} !== {1'b1, 1'b1, 32'h40400000}) begin
      n_fail++;
      $display("FAIL b2b_after_pop: got rdy=%b v=%b data=%h, required 1 1 40400000", in_ready, wb_valid, wb_data);
    end
    tick();
    n_checks++;
    if ({wb_valid, fflags} !== {1'b0, 5'b00111}) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b ff=%b, required 0 00111", wb_valid, fflags);
    end
  endtask

  task automatic test_csr_race();
    wb_ready  = 1'b0;
    csr_we    = 1'b1;
    csr_wdata = 5'b00001;
    tick();
    csr_we = 1'b0;
    n_checks++;
    if (fflags !== 5'b00001) begin n_fail++; $display("FAIL csr_write: got %b, required 00001", fflags); end
    offer(32'h3F000000, 5'b10000, 5'd9);
    csr_we    = 1'b1;
    csr_wdata = 5'b00000;
    wb_ready  = 1'b1;
    tick();
    csr_we = 1'b0;
    n_checks++;
    if (fflags !== 5'b10000) begin n_fail++; $display("FAIL csr_pop_race: got %b, required 10000", fflags); end
  endtask

  task automatic test_push_pop_same_cycle();
    wb_ready = 1'b0;
    offer(32'h11111111, 5'b01000, 5'd10);
    wb_ready = 1'b1;
    offer(32'h22222222, 5'b00000, 5'd11);
    n_checks++;
    if ({wb_valid, busy, in_ready, wb_data, wb_rd} !== {1'b1, 1'b1, 1'b1, 32'h22222222, 5'd11}) begin
      n_fail++;
      $display("FAIL simul_push_pop: got v=%b busy=%b rdy=%b data=%h rd=%0d, required 1 1 1 22222222 11",
               wb_valid, busy, in_ready, wb_data, wb_rd);
    end
    tick();
    n_checks++;
    if ({wb_valid, fflags} !== {1'b0, 5'b11000}) begin
      n_fail++;
      $display("FAIL simul_drain: got v=%b ff=%b, required 0 11000", wb_valid, fflags);
    end
  endtask

  task automatic test_nan();
    wb_ready = 1'b0;
    offer(32'h7FA00001, 5'b00000, 5'd7);
    n_checks++;
    if (wb_data !== exp_data(32'h7FA00001)) begin
      n_fail++;
      $display("FAIL nan_canon: got %h, required %h", wb_data, exp_data(32'h7FA00001));
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    offer(32'h7F800000, 5'b00000, 5'd8);
    n_checks++;
    if (wb_data !== 32'h7F800000) begin n_fail++; $display("FAIL inf_kept: got %h, required 7f800000", wb_data); end
    wb_ready = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    wb_ready = 1'b0;
    offer(32'hAAAA5555, 5'b11111, 5'd12);
    offer(32'h5555AAAA, 5'b11111, 5'd13);
    n_checks++;
    if ({in_ready, busy} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mreset_full: got rdy=%b busy=%b, required 0 1", in_ready, busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    n_checks++;
    if ({wb_valid, busy, fflags, in_ready} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mreset_state: got v=%b busy=%b ff=%b rdy=%b, required 0 0 00000 1",
               wb_valid, busy, fflags, in_ready);
    end
    wb_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({wb_valid, fflags} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL mreset_no_write: got v=%b ff=%b, required 0 00000", wb_valid, fflags);
    end
  endtask

  task automatic test_random();
    acc_flags = 5'd0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_result = $urandom();
      in_flags  = 5'($urandom_range(0, 31));
      in_rd     = 5'($urandom_range(0, 31));
      wb_ready  = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        sb.push_back('{data: exp_data(in_result), flags: in_flags, rd: in_rd});
        acc_flags = acc_flags | in_flags;
      end
      tick();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 10 && wb_valid; i++) tick();
    n_checks++;
    if ({wb_valid, sb.size() == 0} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL random_drain: got v=%b pending=%0d, required 0 0", wb_valid, sb.size());
    end
    n_checks++;
    if (fflags !== acc_flags) begin
      n_fail++;
      $display("FAIL random_flags: got %b, required %b", fflags, acc_flags);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = 32'd0;
    in_flags  = 5'd0;
    in_rd     = 5'd0;
    wb_ready  = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = 5'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_csr_race();
    test_push_pop_same_cycle();
    test_nan();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
